// File: rtl/uart_param_pkg.sv
// Shared types and helpers for the parameterised UART.
package uart_param_pkg;

  // Parity mode encodings for cfg_parity; 2'b11 behaves like PAR_NONE.
  localparam logic [1:0] PAR_NONE     = 2'b00;
  localparam logic [1:0] PAR_EVEN     = 2'b01;
  localparam logic [1:0] PAR_ODD      = 2'b10;
  localparam logic [1:0] PAR_NONE_ALT = 2'b11;

  typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxParity, TxStop} tx_state_e;
  typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxParity, RxStop} rx_state_e;

  // Data bit code to count: 00=5, 01=6, 10=7, 11=8.
  function automatic logic [3:0] data_bits_count(input logic [1:0] code);
    return 4'd5 + {2'b00, code};
  endfunction

  // Mask that keeps only the active data bits of a byte.
  function automatic logic [7:0] data_mask(input logic [1:0] code);
    return 8'hFF >> (3'd3 - {1'b0, code});
  endfunction

  function automatic logic parity_enabled(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// First-word-fall-through synchronous FIFO; rdata always shows the head entry.
module uart_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      count_q;
  logic             do_wr, do_rd;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  // A read on a full FIFO frees the slot the simultaneous write uses.
  assign do_rd = rd && !empty;
  assign do_wr = wr && (!full || do_rd);
  assign rdata = mem_q[rptr_q];

  // Pointer and occupancy update; pointers wrap modulo DEPTH.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_wr) wptr_q <= wptr_q + AW'(1);
      if (do_rd) rptr_q <= rptr_q + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wptr_q] <= wdata;
  end

endmodule

// File: rtl/uart_param.sv
// Parameterised UART with TX/RX FIFOs, configurable framing and sticky errors.
// Optional feature: define UART_LOOPBACK_EN to add the loopback input.
module uart_param
  import uart_param_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned OSR        = 16,
  parameter int unsigned DIV_W      = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [DIV_W-1:0] baud_div,
  input  logic [1:0]       cfg_data_bits,
  input  logic [1:0]       cfg_parity,
  input  logic             cfg_stop2,
  input  logic             wr_uart,
  input  logic [7:0]       data_w,
  output logic             tx_full,
  output logic             tx_busy,
  output logic             tx,
`ifdef UART_LOOPBACK_EN
  input  logic             loopback,
`endif
  input  logic             rx,
  input  logic             rd_uart,
  output logic [7:0]       data_r,
  output logic             rx_empty,
  output logic             par_err,
  output logic             fr_err,
  output logic             ovr_err,
  input  logic             err_clr
);

  localparam int unsigned OW = $clog2(OSR);

  // ---------------- baud tick ----------------
  logic [DIV_W-1:0] baud_cnt_q;
  logic             tick;

  assign tick = (baud_cnt_q == baud_div);

  // Free-running divider; also wraps if baud_div is lowered below the count.
  always_ff @(posedge clk) begin
    if (!reset_n)                   baud_cnt_q <= '0;
    else if (baud_cnt_q >= baud_div) baud_cnt_q <= '0;
    else                            baud_cnt_q <= baud_cnt_q + DIV_W'(1);
  end

  // ---------------- TX path ----------------
  logic       tx_pop, tx_fifo_empty;
  logic [7:0] tx_fifo_dout;

  uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .wr      (wr_uart),
    .wdata   (data_w),
    .rd      (tx_pop),
    .rdata   (tx_fifo_dout),
    .full    (tx_full),
    .empty   (tx_fifo_empty)
  );

  tx_state_e     tx_state_q, tx_state_d;
  logic [OW-1:0] tx_tcnt_q, tx_tcnt_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic [2:0]    tx_last_q, tx_last_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic [1:0]    tx_par_q, tx_par_d;
  logic          tx_stop2_q, tx_stop2_d;
  logic          tx_bit_end, tx_par_bit, tx_out;

  assign tx_bit_end = tick && (tx_tcnt_q == OW'(OSR - 1));
  // Data is masked at latch time, so the reduction covers only active bits.
  assign tx_par_bit = (^tx_data_q) ^ (tx_par_q == PAR_ODD);

  // TX state register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tx_state_q <= TxIdle;
      tx_tcnt_q  <= '0;
      tx_bit_q   <= '0;
      tx_last_q  <= '0;
      tx_data_q  <= '0;
      tx_par_q   <= PAR_NONE;
      tx_stop2_q <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_tcnt_q  <= tx_tcnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_last_q  <= tx_last_d;
      tx_data_q  <= tx_data_d;
      tx_par_q   <= tx_par_d;
      tx_stop2_q <= tx_stop2_d;
    end
  end

  // TX next state, FIFO pop and serial output level.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_tcnt_d  = tx_tcnt_q;
    tx_bit_d   = tx_bit_q;
    tx_last_d  = tx_last_q;
    tx_data_d  = tx_data_q;
    tx_par_d   = tx_par_q;
    tx_stop2_d = tx_stop2_q;
    tx_pop     = 1'b0;
    tx_out     = 1'b1;
    if (tick) tx_tcnt_d = tx_bit_end ? '0 : tx_tcnt_q + OW'(1);
    case (tx_state_q)
      TxIdle: begin
        tx_tcnt_d = '0;
        if (!tx_fifo_empty) begin
          tx_pop     = 1'b1;
          tx_data_d  = tx_fifo_dout & data_mask(cfg_data_bits);
          tx_last_d  = 3'(data_bits_count(cfg_data_bits) - 4'd1);
          tx_par_d   = cfg_parity;
          tx_stop2_d = cfg_stop2;
          tx_bit_d   = '0;
          tx_state_d = TxStart;
        end
      end
      TxStart: begin
        tx_out = 1'b0;
        if (tx_bit_end) tx_state_d = TxData;
      end
      TxData: begin
        tx_out = tx_data_q[tx_bit_q];
        if (tx_bit_end) begin
          if (tx_bit_q == tx_last_q) begin
            tx_bit_d   = '0;
            tx_state_d = parity_enabled(tx_par_q) ? TxParity : TxStop;
          end else begin
            tx_bit_d = tx_bit_q + 3'd1;
          end
        end
      end
      TxParity: begin
        tx_out = tx_par_bit;
        if (tx_bit_end) tx_state_d = TxStop;
      end
      TxStop: begin
        // tx_bit_q counts stop bits already sent.
        if (tx_bit_end) begin
          if (tx_stop2_q && (tx_bit_q == 3'd0)) tx_bit_d = 3'd1;
          else                                 tx_state_d = TxIdle;
        end
      end
      default: tx_state_d = TxIdle;
    endcase
  end

  assign tx      = tx_out;
  assign tx_busy = (tx_state_q != TxIdle);

  // ---------------- RX path ----------------
  logic       rx_line;
  logic [1:0] rx_sync_q;
  logic       rx_s;

`ifdef UART_LOOPBACK_EN
  assign rx_line = loopback ? tx_out : rx;
`else
  assign rx_line = rx;
`endif
  assign rx_s = rx_sync_q[1];

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge clk) begin
    if (!reset_n) rx_sync_q <= 2'b11;
    else          rx_sync_q <= {rx_sync_q[0], rx_line};
  end

  rx_state_e     rx_state_q, rx_state_d;
  logic [OW-1:0] rx_tcnt_q, rx_tcnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [2:0]    rx_last_q, rx_last_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic [1:0]    rx_par_q, rx_par_d;
  logic          rx_pbit_q, rx_pbit_d;
  logic          rx_half_end, rx_bit_end;
  logic          rx_push, fr_set, par_set, ovr_set;
  logic          rx_fifo_full;
  logic [7:0]    rx_fifo_dout;

  assign rx_half_end = tick && (rx_tcnt_q == OW'(OSR / 2 - 1));
  assign rx_bit_end  = tick && (rx_tcnt_q == OW'(OSR - 1));

  // RX state register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rx_state_q <= RxIdle;
      rx_tcnt_q  <= '0;
      rx_bit_q   <= '0;
      rx_last_q  <= '0;
      rx_data_q  <= '0;
      rx_par_q   <= PAR_NONE;
      rx_pbit_q  <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_tcnt_q  <= rx_tcnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_last_q  <= rx_last_d;
      rx_data_q  <= rx_data_d;
      rx_par_q   <= rx_par_d;
      rx_pbit_q  <= rx_pbit_d;
    end
  end

  // RX next state; samples mid-bit after the half-bit start qualification.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_tcnt_d  = rx_tcnt_q;
    rx_bit_d   = rx_bit_q;
    rx_last_d  = rx_last_q;
    rx_data_d  = rx_data_q;
    rx_par_d   = rx_par_q;
    rx_pbit_d  = rx_pbit_q;
    rx_push    = 1'b0;
    fr_set     = 1'b0;
    par_set    = 1'b0;
    if (tick) rx_tcnt_d = rx_bit_end ? '0 : rx_tcnt_q + OW'(1);
    case (rx_state_q)
      RxIdle: begin
        rx_tcnt_d = '0;
        if (!rx_s) begin
          rx_last_d  = 3'(data_bits_count(cfg_data_bits) - 4'd1);
          rx_par_d   = cfg_parity;
          rx_data_d  = '0;
          rx_bit_d   = '0;
          rx_state_d = RxStart;
        end
      end
      RxStart: begin
        if (rx_half_end) begin
          rx_tcnt_d  = '0;
          rx_state_d = rx_s ? RxIdle : RxData;
        end
      end
      RxData: begin
        if (rx_bit_end) begin
          rx_data_d[rx_bit_q] = rx_s;
          if (rx_bit_q == rx_last_q) begin
            rx_state_d = parity_enabled(rx_par_q) ? RxParity : RxStop;
          end else begin
            rx_bit_d = rx_bit_q + 3'd1;
          end
        end
      end
      RxParity: begin
        if (rx_bit_end) begin
          rx_pbit_d  = rx_s;
          rx_state_d = RxStop;
        end
      end
      RxStop: begin
        // Only the first stop bit is checked; the FSM is ready for a new start at once.
        if (rx_bit_end) begin
          rx_push    = 1'b1;
          fr_set     = !rx_s;
          par_set    = parity_enabled(rx_par_q) &&
                       ((^rx_data_q) ^ rx_pbit_q ^ (rx_par_q == PAR_ODD));
          rx_state_d = RxIdle;
        end
      end
      default: rx_state_d = RxIdle;
    endcase
  end

  uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .wr      (rx_push),
    .wdata   (rx_data_q),
    .rd      (rd_uart),
    .rdata   (rx_fifo_dout),
    .full    (rx_fifo_full),
    .empty   (rx_empty)
  );

  assign ovr_set = rx_push && rx_fifo_full && !rd_uart;
  assign data_r  = rx_empty ? 8'h00 : rx_fifo_dout;

  // Sticky error flags; a new error beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      par_err <= 1'b0;
      fr_err  <= 1'b0;
      ovr_err <= 1'b0;
    end else begin
      par_err <= par_set | (par_err & ~err_clr);
      fr_err  <= fr_set  | (fr_err  & ~err_clr);
      ovr_err <= ovr_set | (ovr_err & ~err_clr);
    end
  end

endmodule

// File: tb/tb_uart_param.sv
// Self-checking bench for uart_param: frame vectors, corner sequences, random bursts.
module tb_uart_param;

  localparam int DEPTH = 4;
  localparam int OSR   = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] baud_div = '0;
  logic [1:0]  cfg_data_bits = 2'b11;
  logic [1:0]  cfg_parity = 2'b00;
  logic        cfg_stop2 = 1'b0;
  logic        wr_uart = 1'b0;
  logic [7:0]  data_w = '0;
  logic        tx_full, tx_busy, tx;
  logic        loopback = 1'b0;
  logic        rx;
  logic        rx_drv = 1'b1;
  logic        wire_mode = 1'b0;
  logic        rd_uart = 1'b0;
  logic [7:0]  data_r;
  logic        rx_empty, par_err, fr_err, ovr_err;
  logic        err_clr = 1'b0;

  assign rx = wire_mode ? tx : rx_drv;

  always #5 clk = ~clk;

  uart_param #(.FIFO_DEPTH(DEPTH), .OSR(OSR), .DIV_W(16)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .baud_div      (baud_div),
    .cfg_data_bits (cfg_data_bits),
    .cfg_parity    (cfg_parity),
    .cfg_stop2     (cfg_stop2),
    .wr_uart       (wr_uart),
    .data_w        (data_w),
    .tx_full       (tx_full),
    .tx_busy       (tx_busy),
    .tx            (tx),
`ifdef UART_LOOPBACK_EN
    .loopback      (loopback),
`endif
    .rx            (rx),
    .rd_uart       (rd_uart),
    .data_r        (data_r),
    .rx_empty      (rx_empty),
    .par_err       (par_err),
    .fr_err        (fr_err),
    .ovr_err       (ovr_err),
    .err_clr       (err_clr)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  // Reference model: list of line levels for one frame, one entry per bit.
  bit         frame_q[$];
  logic [7:0] exp_q[$];

  task automatic build_frame(input logic [7:0] d, input logic [1:0] code,
                             input logic [1:0] pm, input bit stop2);
    int n;
    int ones;
    n = 5 + int'(code);
    ones = 0;
    frame_q.delete();
    frame_q.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      frame_q.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (pm == 2'b01) frame_q.push_back(bit'(ones % 2));
    else if (pm == 2'b10) frame_q.push_back(bit'(1 - ones % 2));
    frame_q.push_back(1'b1);
    if (stop2) frame_q.push_back(1'b1);
  endtask

  function automatic logic [7:0] keep_bits(input logic [7:0] d, input logic [1:0] code);
    int n;
    n = 5 + int'(code);
    return d & 8'((32'd1 << n) - 1);
  endfunction

  task automatic set_cfg(input logic [1:0] code, input logic [1:0] pm, input bit s2);
    cfg_data_bits = code;
    cfg_parity    = pm;
    cfg_stop2     = s2;
  endtask

  task automatic pop_rx();
    rd_uart = 1'b1;
    @(negedge clk);
    rd_uart = 1'b0;
  endtask

  task automatic clear_errs();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    @(negedge clk);
  endtask

  // Drive a frame bit by bit on rx (baud_div=0 assumed), with optional corruption.
  task automatic send_rx(input logic [7:0] d, input logic [1:0] code, input logic [1:0] pm,
                         input bit stop_low, input bit flip_par);
    build_frame(d, code, pm, 1'b0);
    if (flip_par) frame_q[frame_q.size()-2] = !frame_q[frame_q.size()-2];
    if (stop_low) frame_q[frame_q.size()-1] = 1'b0;
    foreach (frame_q[i]) begin
      rx_drv = frame_q[i];
      repeat (OSR) @(negedge clk);
    end
    rx_drv = 1'b1;
    repeat (2 * OSR) @(negedge clk);
  endtask

  // Pop bytes as they arrive and score them against exp_q.
  task automatic collect(input string name, input int n, input int bound);
    int got;
    int cyc;
    got = 0;
    cyc = 0;
    while (got < n && cyc < bound) begin
      @(negedge clk);
      rd_uart = 1'b0;
      cyc++;
      if (!rx_empty) begin
        check(name, 32'(data_r), 32'(exp_q.pop_front()));
        rd_uart = 1'b1;
        got++;
      end
    end
    @(negedge clk);
    rd_uart = 1'b0;
    check({name, "_count"}, 32'(got), 32'(n));
  endtask

  task automatic wait_tx_idle(input int bound);
    int c;
    c = 0;
    while (tx_busy && c < bound) begin
      @(negedge clk);
      c++;
    end
    check("tx_drain", 32'(tx_busy), 32'd0);
  endtask

  typedef struct {
    logic [7:0] d;
    logic [1:0] code;
    logic [1:0] pm;
    bit         stop2;
    logic [7:0] exp_d;
    int         exp_pbit;  // -1 when no parity bit
  } vec_t;

  vec_t vecs[7];

  // One looped-back frame: exact tx waveform, busy length, parity bit, received byte.
  task automatic run_vec(input vec_t v);
    int errs;
    int busy;
    int n;
    logic pbit;
    n = 5 + int'(v.code);
    set_cfg(v.code, v.pm, v.stop2);
    data_w  = v.d;
    wr_uart = 1'b1;
    @(negedge clk);
    wr_uart = 1'b0;
    errs = (tx !== 1'b1) ? 1 : 0;
    busy = 0;
    pbit = 1'bx;
    build_frame(v.d, v.code, v.pm, v.stop2);
    for (int i = 0; i < frame_q.size() * OSR; i++) begin
      @(negedge clk);
      // Config changes mid-frame must not disturb the frame in flight.
      if (i == 20) set_cfg(~v.code, ~v.pm, ~v.stop2);
      if (tx !== frame_q[i / OSR]) errs++;
      if (tx_busy === 1'b1) busy++;
      if (i == (1 + n) * OSR + OSR / 2) pbit = tx;
    end
    @(negedge clk);
    if (tx !== 1'b1 || tx_busy !== 1'b0) errs++;
    check("tx_wave", 32'(errs), 32'd0);
    check("tx_busy_len", 32'(busy), 32'(frame_q.size() * OSR));
    if (v.exp_pbit >= 0) check("parity_bit", 32'(pbit), 32'(v.exp_pbit));
    check("rx_has_byte", 32'(rx_empty), 32'd0);
    check("rx_data", 32'(data_r), 32'(v.exp_d));
    check("rx_par_err", 32'(par_err), 32'd0);
    check("rx_fr_err", 32'(fr_err), 32'd0);
    pop_rx();
    check("rx_empty_after_pop", 32'(rx_empty), 32'd1);
  endtask

  initial begin
    vecs[0] = '{d: 8'hA5, code: 2'b11, pm: 2'b00, stop2: 1'b0, exp_d: 8'hA5, exp_pbit: -1};
    vecs[1] = '{d: 8'h53, code: 2'b10, pm: 2'b01, stop2: 1'b1, exp_d: 8'h53, exp_pbit: 0};
    vecs[2] = '{d: 8'h00, code: 2'b11, pm: 2'b10, stop2: 1'b0, exp_d: 8'h00, exp_pbit: 1};
    vecs[3] = '{d: 8'hFF, code: 2'b00, pm: 2'b00, stop2: 1'b0, exp_d: 8'h1F, exp_pbit: -1};
    vecs[4] = '{d: 8'hC7, code: 2'b01, pm: 2'b01, stop2: 1'b0, exp_d: 8'h07, exp_pbit: 1};
    vecs[5] = '{d: 8'hFE, code: 2'b10, pm: 2'b10, stop2: 1'b1, exp_d: 8'h7E, exp_pbit: 1};
    vecs[6] = '{d: 8'h3C, code: 2'b11, pm: 2'b11, stop2: 1'b1, exp_d: 8'h3C, exp_pbit: -1};

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_tx_busy", 32'(tx_busy), 32'd0);
    check("rst_tx_full", 32'(tx_full), 32'd0);
    check("rst_rx_empty", 32'(rx_empty), 32'd1);
    check("rst_data_r", 32'(data_r), 32'd0);
    check("rst_errs", 32'({par_err, fr_err, ovr_err}), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Table of looped-back frames at baud_div=0.
    wire_mode = 1'b1;
    foreach (vecs[k]) run_vec(vecs[k]);

    // Short low glitch on rx must not start a frame.
    wire_mode = 1'b0;
    set_cfg(2'b11, 2'b00, 1'b0);
    rx_drv = 1'b0;
    repeat (4) @(negedge clk);
    rx_drv = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_rx_empty", 32'(rx_empty), 32'd1);
    send_rx(8'h5A, 2'b11, 2'b00, 1'b0, 1'b0);
    check("post_glitch_data", 32'(data_r), 32'h5A);
    check("post_glitch_fr", 32'(fr_err), 32'd0);
    pop_rx();

    // Framing error: byte still delivered, flag sticky until err_clr.
    send_rx(8'h3C, 2'b11, 2'b00, 1'b1, 1'b0);
    check("fr_err_set", 32'(fr_err), 32'd1);
    check("fr_byte", 32'(data_r), 32'h3C);
    check("fr_no_par", 32'(par_err), 32'd0);
    repeat (20) @(negedge clk);
    check("fr_err_sticky", 32'(fr_err), 32'd1);
    clear_errs();
    check("fr_err_clr", 32'(fr_err), 32'd0);
    pop_rx();
    check("fr_after_pop", 32'(rx_empty), 32'd1);

    // Parity error on 8E1.
    set_cfg(2'b11, 2'b01, 1'b0);
    send_rx(8'h96, 2'b11, 2'b01, 1'b0, 1'b1);
    check("par_err_set", 32'(par_err), 32'd1);
    check("par_byte", 32'(data_r), 32'h96);
    check("par_no_fr", 32'(fr_err), 32'd0);
    clear_errs();
    check("par_err_clr", 32'(par_err), 32'd0);
    pop_rx();

    // RX overrun: DEPTH+1 frames without reads.
    set_cfg(2'b11, 2'b00, 1'b0);
    for (int i = 0; i <= DEPTH; i++) send_rx(8'h10 + 8'(i), 2'b11, 2'b00, 1'b0, 1'b0);
    check("ovr_err_set", 32'(ovr_err), 32'd1);
    for (int i = 0; i < DEPTH; i++) begin
      check("ovr_fifo_data", 32'(data_r), 32'(8'h10 + 8'(i)));
      pop_rx();
    end
    check("ovr_fifo_drained", 32'(rx_empty), 32'd1);
    clear_errs();
    check("ovr_err_clr", 32'(ovr_err), 32'd0);

    // TX FIFO full with the transmitter stalled on a slow baud rate.
    wire_mode = 1'b1;
    baud_div  = 16'd1000;
    data_w    = 8'hC3;
    wr_uart   = 1'b1;
    @(negedge clk);
    wr_uart = 1'b0;
    repeat (3) @(negedge clk);
    check("stall_busy", 32'(tx_busy), 32'd1);
    check("stall_not_full", 32'(tx_full), 32'd0);
    exp_q.delete();
    exp_q.push_back(8'hC3);
    for (int i = 0; i <= DEPTH; i++) begin
      data_w  = 8'h20 + 8'(i);
      wr_uart = 1'b1;
      if (i < DEPTH) exp_q.push_back(8'h20 + 8'(i));
      @(negedge clk);
    end
    wr_uart = 1'b0;
    check("tx_full_set", 32'(tx_full), 32'd1);
    baud_div = 16'd0;
    collect("txfull_rx", DEPTH + 1, (DEPTH + 1) * 10 * OSR + 400);
    repeat (400) @(negedge clk);
    check("txfull_no_extra", 32'(rx_empty), 32'd1);
    check("txfull_cleared", 32'(tx_full), 32'd0);

    // Reset in the middle of the data bits.
    set_cfg(2'b11, 2'b00, 1'b0);
    data_w  = 8'h00;
    wr_uart = 1'b1;
    @(negedge clk);
    wr_uart = 1'b0;
    repeat (40) @(negedge clk);
    check("mid_data_tx_low", 32'(tx), 32'd0);
    reset_n = 1'b0;
    @(negedge clk);
    check("midrst_tx", 32'(tx), 32'd1);
    check("midrst_busy", 32'(tx_busy), 32'd0);
    check("midrst_rx_empty", 32'(rx_empty), 32'd1);
    check("midrst_data_r", 32'(data_r), 32'd0);
    reset_n = 1'b1;
    repeat (300) @(negedge clk);
    check("midrst_no_byte", 32'(rx_empty), 32'd1);
    check("midrst_tx_idle", 32'(tx), 32'd1);

    // Random bursts of three bytes under random framing and baud.
    for (int b = 0; b < 5; b++) begin
      logic [1:0] code;
      logic [1:0] pm;
      logic [7:0] d;
      code     = 2'($urandom_range(0, 3));
      pm       = 2'($urandom_range(0, 3));
      set_cfg(code, pm, 1'($urandom_range(0, 1)));
      baud_div = 16'($urandom_range(0, 2));
      exp_q.delete();
      for (int k = 0; k < 3; k++) begin
        d       = 8'($urandom);
        data_w  = d;
        wr_uart = 1'b1;
        exp_q.push_back(keep_bits(d, code));
        @(negedge clk);
      end
      wr_uart = 1'b0;
      collect("rand_rx", 3, 3 * 12 * OSR * 3 + 300);
      wait_tx_idle(1000);
      repeat (OSR) @(negedge clk);
    end
    check("rand_errs", 32'({par_err, fr_err, ovr_err}), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/uart_param.md
UART_PARAM -- requirements
Module: uart_param

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16: entries per TX/RX FIFO, a power of 2 and at least 2.
REQ-002 SHALL have parameter OSR, default 16: baud ticks per bit, even and at least 4.
REQ-003 SHALL have parameter DIV_W, default 16: width of baud_div.
REQ-004 SHALL have ports:
- clk  in  1  sole clock.
- reset_n  in  1  synchronous, active-low reset.
- baud_div  in  DIV_W  tick period minus 1, in clk cycles.
- cfg_data_bits  in  2  data bits per frame: 00=5, 01=6, 10=7, 11=8.
- cfg_parity  in  2  00=none, 01=even, 10=odd, 11=none.
- cfg_stop2  in  1  1 selects two stop bits.
- wr_uart  in  1  push data_w into the TX FIFO.
- data_w  in  8  TX byte; unused MSBs are ignored.
- tx_full  out  1  TX FIFO full.
- tx_busy  out  1  TX FSM not IDLE.
- tx  out  1  serial out.
- rx  in  1  serial in, asynchronous.
- rd_uart  in  1  pop the RX FIFO.
- data_r  out  8  RX FIFO head, zero-extended; 0 when rx_empty.
- rx_empty  out  1  RX FIFO empty.
- par_err / fr_err / ovr_err  out  1 each  sticky parity, framing and overrun error flags.
- err_clr  in  1  clears all three error flags.

Function
REQ-005 Baud counter SHALL count 0..baud_div, pulse tick for one cycle when the count equals baud_div, then wrap to 0; baud_div=0 gives a tick every cycle.
REQ-006 TX FSM SHALL use states IDLE, START, DATA, PARITY, STOP; each bit SHALL last exactly OSR ticks.
REQ-007 In IDLE with the TX FIFO non-empty, the TX FSM SHALL pop one entry, latch the byte and cfg_*, and enter START on the next cycle.
REQ-008 Frame SHALL be: start (0), data LSB first, optional parity, then 1 or 2 stop bits (1); cfg changes mid-frame SHALL have no effect.
REQ-009 Even parity SHALL make the count of 1s over data plus parity even; odd parity SHALL make it odd.
REQ-010 rx SHALL pass through a 2-flop synchroniser before use.
REQ-011 RX FSM SHALL use states IDLE, START, DATA, PARITY, STOP and latch cfg_* on the falling edge that leaves IDLE.
REQ-012 In START, the RX FSM SHALL wait OSR/2 ticks; if the line is high it SHALL return to IDLE (glitch), otherwise it SHALL sample each later bit every OSR ticks.
REQ-013 On the first stop-bit sample, the RX FSM SHALL set fr_err if the line is low and par_err on parity mismatch, and SHALL push the data; it SHALL then return to IDLE without sampling a second stop bit.
REQ-014 A push to a full RX FIFO SHALL drop the byte and set ovr_err.
REQ-015 Error flags SHALL be sticky; err_clr SHALL clear them, and a set in the same cycle as err_clr SHALL win.
REQ-016 Both FIFOs SHALL be first-word-fall-through:
- write to full: ignored;
- read from empty: ignored;
- read+write when full: both performed;
- read+write when empty: write only.
REQ-017 FIFO pointers SHALL wrap modulo FIFO_DEPTH; tx_full and rx_empty SHALL update on the cycle after the causing push or pop.

Reset
REQ-018 While reset_n=0 at a clk edge:
- tx=1, tx_busy=0, tx_full=0;
- rx_empty=1, data_r=0;
- par_err=fr_err=ovr_err=0;
- both FSMs in IDLE;
- baud counter at 0;
- FIFOs flushed.
REQ-019 Reset mid-frame SHALL abort the frame; no partial byte SHALL enter the RX FIFO.

Configuration
REQ-020 With UART_LOOPBACK_EN defined, the block SHALL add input loopback (1 bit); loopback=1 SHALL feed the internal tx to the RX synchroniser input in place of rx while tx still drives the pin. Without the macro, the port SHALL be absent and rx SHALL always be used.

Structure
REQ-021 Package uart_param_pkg SHALL hold:
- parity-mode constants;
- TX and RX state enums;
- data-bit-code-to-count function.
REQ-022 Sub-module uart_sync_fifo (parameters WIDTH, DEPTH) SHALL be instanced twice: TX FIFO of width 8, RX FIFO of width 8.

Verification
REQ-023 Bench SHALL cover these scenarios:
- baud_div=0, OSR=16, 8N1, write 8'hA5: tx is low 16 cycles, then bits 1,0,1,0,0,1,0,1 at 16 cycles each, then high; tx_busy is 1 for 160 cycles.
- Loopback (or tx wired to rx), 7E2, byte 8'h53: data_r=8'h53, par_err=0; 8O1, byte 8'h00: parity bit sent is 1.
- 4-cycle low glitch on rx with baud_div=0: RX FSM returns to IDLE, rx_empty stays 1.
- Frame with stop bit forced low: fr_err=1 and byte pushed; err_clr pulse: fr_err=0.
- FIFO_DEPTH+1 frames received with no rd_uart: FIFO holds the first FIFO_DEPTH bytes, ovr_err=1; write FIFO_DEPTH+1 bytes with TX stalled: tx_full=1 and the extra byte is ignored.
- reset_n low mid-DATA: tx=1 next cycle, rx_empty=1, no byte delivered.
